// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: walks the byte-wide program ROM, reassembles
// 1/2/3-byte instructions into one word, and hands each word to the control
// unit over a valid/ready handshake. Branch redirects and the END opcode
// steer the sequence.
module instr_fetch_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [7:0]  rom_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [7:0]  instr_opcode,
    output logic [15:0] instr_operand,
    output logic [7:0]  instr_pc,
    input  logic        branch_valid,
    input  logic [7:0]  branch_target,
    output logic        busy,
    output logic        halted,
    output logic [15:0] instr_count
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FETCH_OP = 3'd1;
    localparam logic [2:0] S_FETCH_B1 = 3'd2;
    localparam logic [2:0] S_FETCH_B2 = 3'd3;
    localparam logic [2:0] S_ISSUE    = 3'd4;
    localparam logic [2:0] S_HALT     = 3'd5;

    localparam logic [7:0] OP_END = 8'hAA;

    // Total instruction length in bytes, decoded from the opcode byte.
    function automatic logic [1:0] instr_len(input logic [7:0] op);
        logic [1:0] len;
        case (op)
            8'h01, 8'h02, 8'h08, 8'h09: len = 2'd3;
            8'h07:                      len = 2'd2;
            default:                    len = 2'd1;
        endcase
        return len;
    endfunction

    // Instruction counter increment that sticks at all-ones.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [2:0]  state_q,   state_d;
    logic [7:0]  pc_q,      pc_d;
    logic [7:0]  opcode_q,  opcode_d;
    logic [15:0] operand_q, operand_d;
    logic [7:0]  ipc_q,     ipc_d;
    logic [15:0] count_q,   count_d;
    logic        redirect;

    // A redirect only applies while an instruction stream is active.
    always_comb begin
        redirect = branch_valid &&
                   (state_q inside {S_FETCH_OP, S_FETCH_B1, S_FETCH_B2, S_ISSUE});
    end

    // Next-state and datapath updates for the fetch sequencer.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        ipc_d     = ipc_q;
        count_d   = count_q;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_d    = 8'h00;
                    count_d = 16'h0000;
                    state_d = S_FETCH_OP;
                end
            end
            S_FETCH_OP: begin
                opcode_d  = rom_data;
                ipc_d     = pc_q;
                operand_d = 16'h0000;
                pc_d      = pc_q + 8'd1;
                state_d   = (instr_len(rom_data) == 2'd1) ? S_ISSUE : S_FETCH_B1;
            end
            S_FETCH_B1: begin
                pc_d = pc_q + 8'd1;
                if (instr_len(opcode_q) == 2'd2) begin
                    operand_d = {8'h00, rom_data};
                    state_d   = S_ISSUE;
                end else begin
                    operand_d = {rom_data, 8'h00};
                    state_d   = S_FETCH_B2;
                end
            end
            S_FETCH_B2: begin
                operand_d = {operand_q[15:8], rom_data};
                pc_d      = pc_q + 8'd1;
                state_d   = S_ISSUE;
            end
            S_ISSUE: begin
                if (instr_ready) begin
                    count_d = sat_inc(count_q);
                    state_d = (opcode_q == OP_END) ? S_HALT : S_FETCH_OP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The redirect wins over sequential flow and over END->HALT, but a
        // handshake in the same cycle has already been counted above.
        if (redirect) begin
            pc_d    = branch_target;
            state_d = S_FETCH_OP;
        end
    end

    // State and datapath registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc_q      <= 8'h00;
            opcode_q  <= 8'h00;
            operand_q <= 16'h0000;
            ipc_q     <= 8'h00;
            count_q   <= 16'h0000;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            ipc_q     <= ipc_d;
            count_q   <= count_d;
        end
    end

    // Outputs come straight from registers or from decoding the state register.
    always_comb begin
        rom_addr      = pc_q;
        instr_valid   = (state_q == S_ISSUE);
        instr_opcode  = opcode_q;
        instr_operand = operand_q;
        instr_pc      = ipc_q;
        busy          = (state_q != S_IDLE) && (state_q != S_HALT);
        halted        = (state_q == S_HALT);
        instr_count   = count_q;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch sequencer for the image-processing processor. Drives the byte-wide combinational program ROM (8-bit address in, 8-bit data out same cycle) and reassembles variable-length instructions (opcode plus 0/1/2 operand bytes) into one decoded word. Presents each word to the control unit over a valid/ready handshake. Accepts branch redirects and stops on the END opcode.

## Interface
- No parameters; widths fixed by the ROM (8-bit address, 8-bit data).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start` in 1: one-cycle pulse; begins fetching at address 0x00 from IDLE or HALT.
- `rom_addr` out 8: ROM address, equal to the internal PC register.
- `rom_data` in 8: ROM output for `rom_addr`, valid in the same cycle.
- `instr_valid` out 1: instruction word available.
- `instr_ready` in 1: control unit accepts the word.
- `instr_opcode` out 8: opcode byte.
- `instr_operand` out 16: operand, big-endian (first operand byte is the MSB).
- `instr_pc` out 8: ROM address of the opcode byte.
- `branch_valid` in 1: redirect request.
- `branch_target` in 8: redirect address.
- `busy` out 1: high in every state except IDLE and HALT.
- `halted` out 1: high in HALT.
- `instr_count` out 16: number of accepted instructions, saturating at 0xFFFF.

## Operation
- Length decode on the opcode byte:
  - 0x01 (LOAD), 0x02 (STORE), 0x08, 0x09: 3 bytes.
  - 0x07 (JUMP): 2 bytes; operand = {8'h00, byte1}.
  - 0xAA: END, 1 byte.
  - All others: 1 byte; operand = 0x0000.
- States: IDLE, FETCH_OP, FETCH_B1, FETCH_B2, ISSUE, HALT.
- IDLE: outputs quiescent. `start` → PC=0x00, `instr_count`=0, go to FETCH_OP.
- FETCH_OP: latch `rom_data` as opcode, latch PC as `instr_pc`, clear operand, PC+1.
  - Length 1 → ISSUE.
  - Otherwise → FETCH_B1.
- FETCH_B1: latch byte1, PC+1.
  - Length 2 → ISSUE with operand {0x00, byte1}.
  - Length 3 → FETCH_B2 with operand[15:8]=byte1.
- FETCH_B2: operand[7:0]=`rom_data`, PC+1, → ISSUE.
- ISSUE: `instr_valid`=1. Opcode, operand and `instr_pc` stay stable until `instr_ready`.
  - On handshake: `instr_count`+1 (saturating).
  - If the opcode is 0xAA → HALT; otherwise → FETCH_OP.
- HALT: `halted`=1, PC frozen. `start` restarts as from IDLE.
- Branch: `branch_valid` is honoured in FETCH_OP, FETCH_B1, FETCH_B2 and ISSUE; ignored in IDLE and HALT.
  - Effect: abandon any partial or pending instruction, drop `instr_valid` next cycle, PC=`branch_target`, go to FETCH_OP.
  - With a handshake in the same ISSUE cycle: the handshake completes and is counted, the redirect still applies, and the END→HALT transition is superseded by the redirect.
- PC arithmetic is 8-bit modulo; 0xFF+1 wraps to 0x00, including mid-instruction.
- `start` while `busy` is ignored.

## Timing
- Reset values: `rom_addr`=0x00, `instr_valid`=0, `instr_opcode`=0x00, `instr_operand`=0x0000, `instr_pc`=0x00, `busy`=0, `halted`=0, `instr_count`=0, state IDLE.
- `start` sampled at edge N → FETCH_OP during cycle N+1 with `rom_addr`=0x00.
- `instr_valid` rises this many cycles after entry to FETCH_OP:
  - 1-byte instruction: 1 cycle.
  - 2-byte instruction: 2 cycles.
  - 3-byte instruction: 3 cycles.
- Zero-wait throughput (ready held high): one instruction every length+1 cycles.
- Branch sampled at edge N → `rom_addr`=`branch_target` and state FETCH_OP in cycle N+1; `instr_valid`=0 in cycle N+1.
- All outputs are registered; there is no combinational path from `instr_ready` or `branch_valid` to any output.

## Test plan
- ROM {0:0x00, 1:0x01, 2:0x00, 3:0x0D, 4:0xAA}, pulse `start`, ready=1 → words (0x00,0x0000,pc0), (0x01,0x000D,pc1), (0xAA,0x0000,pc4); then `halted`=1, `instr_count`=3, `rom_addr` frozen at 0x05.
- Same ROM, ready held low 5 cycles while the LOAD is issued → `instr_valid`/opcode/operand stable for all 5 cycles; `rom_addr` stays 0x04 until the handshake.
- ROM {0x6D:0x07, 0x6E:0x3D}, branch to 0x6D, then assert `branch_valid`/target 0x3D on the JUMP handshake cycle → JUMP counted; next `rom_addr`=0x3D; the prefetched sequential instruction is never issued.
- ROM with a 3-byte 0x08 at 0xFE (bytes at 0xFF, 0x00) → operand {ROM[0xFF], ROM[0x00]}; PC wraps to 0x01.
- Assert `reset` during FETCH_B1 → all outputs return to reset values asynchronously; `start` afterwards fetches from 0x00 cleanly.
- `branch_valid` in IDLE and in HALT → no state change; `start` from HALT restarts at 0x00 with `instr_count` cleared.
